dht_responder: RTL and testbench
================================

DHT_RESPONDER -- requirements
Module: dht_responder

Interface
REQ-001 The block SHALL expose parameter CYCLES_PER_US, default 100, meaning clk cycles per microsecond tick.
REQ-002 The block SHALL expose parameter START_MIN_US, default 18000, meaning the minimum host start-low width in microseconds that is accepted.
REQ-003 The block SHALL expose parameter RESP_WAIT_US, default 30, meaning the delay from host release to the first driven acknowledge edge.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sensor_data  inout  1  single-wire bus; the block drives only 0 or high-Z, never 1.
REQ-007 hum_int, hum_dec, temp_int, temp_dec  input  8 each  reading values to transmit.
REQ-008 busy  output  1  high from HOST_REL through END_LOW inclusive.
REQ-009 frame_done  output  1  one-cycle pulse on completion of END_LOW.
REQ-010 start_err  output  1  one-cycle pulse when a host start-low is too short.
REQ-011 frame_count  output  8  count of completed frames; wraps 255->0.

Function
REQ-012 sensor_data SHALL be sampled through a 2-flop synchronizer; all line decisions use the synchronized value.
REQ-013 The bus driver SHALL be a registered drive_low flag; the pin is 0 when the flag is set, else high-Z.
REQ-014 A prescaler counting 0..CYCLES_PER_US-1 SHALL generate a us tick; it clears on every state entry, so a phase of N us lasts exactly N*CYCLES_PER_US cycles.
REQ-015 The us counter SHALL be 16 bits wide, saturate at 65535, and clear on every state entry.
REQ-016 In IDLE the driver SHALL be released; a synchronized low moves to HOST_LOW.
REQ-017 In HOST_LOW the driver SHALL be released and microseconds counted; on a synchronized high the state moves to HOST_REL if count >= START_MIN_US, otherwise to IDLE with start_err pulsed.
REQ-018 On the HOST_LOW->HOST_REL transition, the four input bytes SHALL be latched, together with checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, into a 40-bit shift register; later input changes do not affect the frame.
REQ-019 In HOST_REL the driver SHALL be released for RESP_WAIT_US; a synchronized low in this window returns to HOST_LOW with a cleared counter; otherwise the state moves to ACK_LOW.
REQ-020 ACK_LOW SHALL drive low for 80 us, then ACK_HIGH SHALL release for 80 us, then the state moves to BIT_LOW with bit index 39.
REQ-021 BIT_LOW SHALL drive low for 50 us; BIT_HIGH SHALL release for 26 us if the current bit is 0 and 70 us if it is 1.
REQ-022 Bits SHALL be sent MSB first in the order hum_int, hum_dec, temp_int, temp_dec, checksum (40 bits).
REQ-023 After BIT_HIGH of bit 0, END_LOW SHALL drive low for 50 us, then return to IDLE, pulse frame_done, and increment frame_count.
REQ-024 From ACK_LOW through END_LOW, the bus level SHALL be ignored; no host abort is supported.
REQ-025 The first driven-low cycle of ACK_LOW SHALL occur exactly RESP_WAIT_US*CYCLES_PER_US+1 cycles after the HOST_REL entry.

Reset
REQ-026 Asserting reset (low) at any time, including mid-frame, SHALL immediately release the bus, set the state to IDLE, and clear busy, frame_done, start_err, frame_count, the counters, and the shift register.
REQ-027 After reset deasserts, the block SHALL require a full valid start-low before responding.

Verification (CYCLES_PER_US=2, START_MIN_US=10, RESP_WAIT_US=30)
REQ-028 Host low 12 us then release, inputs 0x37,0x00,0x19,0x05 -> ack 80/80 us, decoded bytes 37 00 19 05 55, frame_done pulse, frame_count=1.
REQ-029 Host low 5 us -> start_err one-cycle pulse, pin never driven, busy stays 0, frame_count unchanged.
REQ-030 Inputs 0xFF,0xFF,0x01,0x02 -> transmitted checksum 0x01; a 1-bit high phase measures 140 cycles and a 0-bit high phase measures 52 cycles.
REQ-031 Input bytes changed during BIT_LOW of bit 30 -> transmitted frame still equals the values latched at the HOST_REL entry.
REQ-032 reset asserted during BIT_HIGH of bit 20 -> pin high-Z the same cycle, busy=0, frame_count=0; the next valid start produces a full frame.
REQ-033 256 back-to-back valid frames -> frame_count reads 0 after the 256th frame_done.

Source files
------------

// File: rtl/dht_responder.sv
// dht_responder: single-wire humidity/temperature sensor responder.
// Waits for a valid host start pulse, then sends an ack and a 40-bit reading frame.
module dht_responder #(
  parameter int CYCLES_PER_US = 100,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_WAIT_US  = 30
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sensor_data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       start_err,
  output logic [7:0] frame_count
);
  typedef enum logic [2:0] {IDLE, HOST_LOW, HOST_REL, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW} state_t;
  localparam int PW = CYCLES_PER_US > 1 ? $clog2(CYCLES_PER_US) : 1;
  state_t state, state_n;
  logic [2:0] sync;
  logic [PW-1:0] pre;
  logic [15:0] us, phase_us;
  logic [39:0] sr;
  logic [7:0] checksum;
  logic [5:0] bit_idx;
  logic drive_low, tick, line, fall, phase_end, entry;
  assign sensor_data = drive_low ? 1'b0 : 1'bz;
  // sync[1] is the synchronized level; sync[2] its previous value, so IDLE reacts only to a real falling edge
  assign line = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign tick = pre == PW'(CYCLES_PER_US - 1);
  assign busy = !(state inside {IDLE, HOST_LOW});
  assign entry = state_n != state;
  assign checksum = hum_int + hum_dec + temp_int + temp_dec;
  always_comb begin
    phase_us = 16'd50;
    case (state)
      HOST_REL:          phase_us = 16'(RESP_WAIT_US);
      ACK_LOW, ACK_HIGH: phase_us = 16'd80;
      BIT_HIGH:          phase_us = sr[39] ? 16'd70 : 16'd26;
      default:           phase_us = 16'd50;
    endcase
  end
  // Leaving on the last tick of the phase makes an N-us phase exactly N*CYCLES_PER_US cycles
  assign phase_end = tick && us == phase_us - 16'd1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = fall ? HOST_LOW : IDLE;
      HOST_LOW: state_n = !line ? HOST_LOW : (us >= 16'(START_MIN_US) ? HOST_REL : IDLE);
      HOST_REL: state_n = !line ? HOST_LOW : (phase_end ? ACK_LOW : HOST_REL);
      ACK_LOW:  state_n = phase_end ? ACK_HIGH : ACK_LOW;
      ACK_HIGH: state_n = phase_end ? BIT_LOW : ACK_HIGH;
      BIT_LOW:  state_n = phase_end ? BIT_HIGH : BIT_LOW;
      BIT_HIGH: state_n = !phase_end ? BIT_HIGH : (bit_idx == 6'd0 ? END_LOW : BIT_LOW);
      END_LOW:  state_n = phase_end ? IDLE : END_LOW;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sync        <= '1;
      pre         <= '0;
      us          <= '0;
      sr          <= '0;
      bit_idx     <= '0;
      drive_low   <= 1'b0;
      frame_done  <= 1'b0;
      start_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_n;
      sync       <= {sync[1:0], sensor_data};
      pre        <= (entry || tick) ? '0 : pre + 1'b1;
      us         <= entry ? '0 : (tick && us != 16'hFFFF) ? us + 16'd1 : us;
      // Driver follows the registered state, so the first ack low lands one cycle after the wait expires
      drive_low  <= state inside {ACK_LOW, BIT_LOW, END_LOW};
      frame_done <= state == END_LOW && state_n == IDLE;
      start_err  <= state == HOST_LOW && state_n == IDLE;
      bit_idx    <= state == ACK_HIGH ? 6'd39 : (state == BIT_HIGH && phase_end) ? bit_idx - 6'd1 : bit_idx;
      if (state == HOST_LOW && state_n == HOST_REL)
        sr <= {hum_int, hum_dec, temp_int, temp_dec, checksum};
      else if (state == BIT_HIGH && phase_end)
        sr <= sr << 1;
      if (state == END_LOW && state_n == IDLE)
        frame_count <= frame_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_dht_responder.sv
// tb_dht_responder: scoreboard bench; a line decoder rebuilds each frame and checks it against queued expectations.
module tb_dht_responder;
  logic clk = 1'b0, reset = 1'b0, host_low = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic busy, frame_done, start_err;
  logic [7:0] frame_count;
  wire sensor_data;
  int vectors = 0, miscompares = 0, err_pulses = 0, busy_hits = 0, w = 0;
  bit seen = 0, done_prev = 0, err_prev = 0;
  logic [7:0] exp_cnt = '0;
  logic [39:0] frame_q[$];
  logic [7:0] cnt_q[$];
  // Hand-computed frames: four bytes plus checksum
  logic [39:0] vecs [7] = '{40'h37_00_19_05_55, 40'hFF_FF_01_02_01, 40'hA5_5A_3C_C3_FE,
                            40'h12_34_56_78_14, 40'h0F_F0_11_22_32, 40'h01_02_03_04_0A,
                            40'h80_80_80_80_00};

  assign sensor_data = host_low ? 1'b0 : 1'bz;
  pullup (sensor_data);
  always #5 clk = ~clk;

  dht_responder #(.CYCLES_PER_US(2), .START_MIN_US(10), .RESP_WAIT_US(30)) dut (
    .clk(clk), .reset(reset), .sensor_data(sensor_data),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .busy(busy), .frame_done(frame_done), .start_err(start_err), .frame_count(frame_count));

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic measure(input logic lvl, output int n, output bit ab);
    n = 1;
    ab = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin ab = 1; return; end
      if ((sensor_data !== 1'b0) != lvl) return;
      n++;
      if (n > 4000) begin check("run_timeout", n, 0); ab = 1; return; end
    end
  endtask

  task automatic decode_frame();
    int n;
    bit ab;
    logic [39:0] exp, got;
    exp = frame_q.size() > 0 ? frame_q[0] : 40'h0;
    got = '0;
    measure(1'b0, n, ab);
    if (!ab) begin check("ack_low", n, 160); measure(1'b1, n, ab); end
    if (!ab) check("ack_high", n, 160);
    for (int i = 39; i >= 0 && !ab; i--) begin
      measure(1'b0, n, ab);
      if (!ab) begin check("bit_low", n, 100); measure(1'b1, n, ab); end
      if (!ab) begin got[i] = n > 96; check("bit_high", n, exp[i] ? 140 : 52); end
    end
    if (!ab) begin measure(1'b0, n, ab); if (!ab) check("end_low", n, 100); end
    if (frame_q.size() > 0) void'(frame_q.pop_front());
    if (!ab) check("frame", got, exp);
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (reset && busy) begin
        w = seen ? w + 1 : 0;
        seen = 1;
        if (sensor_data === 1'b0) begin
          check("resp_wait", w, 61);
          seen = 0;
          decode_frame();
        end
      end else seen = 0;
    end
  end

  always @(negedge clk) begin
    if (frame_done) begin
      if (done_prev) check("frame_done_width", 2, 1);
      if (cnt_q.size() == 0) check("frame_done_unexpected", 1, 0);
      else check("frame_count", frame_count, cnt_q.pop_front());
    end
    if (start_err) err_pulses++;
    if (start_err && err_prev) check("start_err_width", 2, 1);
    if (busy) busy_hits++;
    done_prev = frame_done;
    err_prev = start_err;
  end

  task automatic set_in(input logic [39:0] v);
    {hum_int, hum_dec, temp_int, temp_dec} = v[39:8];
  endtask

  task automatic host_pulse(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * 2) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic expect_frame(input logic [39:0] v);
    set_in(v);
    frame_q.push_back(v);
    exp_cnt++;
    cnt_q.push_back(exp_cnt);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 20000) begin @(negedge clk); n++; end
    check("frame_done_seen", frame_done, 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_falls(input int k);
    int n = 0, t = 0;
    logic prev = 1'b1;
    while (n < k && t < 20000) begin
      @(negedge clk);
      t++;
      if (busy && prev && sensor_data === 1'b0) n++;
      prev = sensor_data !== 1'b0;
    end
    check("falls_seen", n, k);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_start_err", start_err, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_line", sensor_data !== 1'b0, 1);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    // Nominal frame
    expect_frame(vecs[0]);
    host_pulse(12);
    wait_done();
    // Too-short start pulse
    err_pulses = 0;
    busy_hits = 0;
    host_pulse(5);
    begin
      int lows = 0;
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (sensor_data === 1'b0) lows++; end
      check("short_line_driven", lows, 0);
    end
    check("short_start_err", err_pulses, 1);
    check("short_busy", busy_hits, 0);
    check("short_frame_count", frame_count, 1);
    // Checksum wrap and bit widths
    expect_frame(vecs[1]);
    host_pulse(12);
    wait_done();
    expect_frame(vecs[2]);
    host_pulse(12);
    wait_done();
    // Inputs change during BIT_LOW of bit 30
    expect_frame(vecs[3]);
    host_pulse(12);
    wait_falls(11);
    set_in(40'h0);
    wait_done();
    // Reset during BIT_HIGH of bit 20
    set_in(vecs[4]);
    frame_q.push_back(vecs[4]);
    host_pulse(12);
    wait_falls(21);
    begin
      int t = 0;
      while (sensor_data === 1'b0 && t < 500) begin @(negedge clk); t++; end
    end
    repeat (10) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("abort_line", sensor_data !== 1'b0, 1);
    check("abort_busy", busy, 0);
    check("abort_frame_count", frame_count, 0);
    exp_cnt = '0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("post_abort_busy", busy, 0);
    expect_frame(vecs[5]);
    host_pulse(12);
    wait_done();
    // Counter wrap: preload 255 and complete one more frame
    @(negedge clk);
    force dut.frame_count = 8'hFF;
    @(negedge clk);
    release dut.frame_count;
    exp_cnt = 8'hFF;
    expect_frame(vecs[6]);
    host_pulse(12);
    wait_done();
    check("wrap_frame_count", frame_count, 0);
    check("frames_pending", frame_q.size(), 0);
    check("counts_pending", cnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
